// File: rtl/pc_seq_pkg.sv
// Shared types for the program-sequencer: operation encoding and the per-cycle priority decode.
// Pure combinational helpers; no state, no flow control.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BRANCH,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_CLR,
    OP_ILLEGAL
  } pc_op_e;

  // Highest-priority request wins; Up is dropped whenever any jump-type input is present.
  function automatic pc_op_e decode_op(input logic clr, input logic call, input logic ret,
                                       input logic load, input logic branch, input logic up);
    if (clr)              return OP_CLR;
    else if (call && ret) return OP_ILLEGAL;
    else if (ret)         return OP_RET;
    else if (call)        return OP_CALL;
    else if (load)        return OP_LOAD;
    else if (branch)      return OP_BRANCH;
    else if (up)          return OP_INC;
    else                  return OP_HOLD;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: push/pop/clear take effect at the clock edge, pop_dat shows the top entry combinationally.
// Push when full and pop when empty are ignored; the caller decides what that means.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 7,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_dat,
  output logic [W-1:0]  pop_dat,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [IDX_W-1:0] wr_idx, top_idx;
  logic             push_ok, pop_ok;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign push_ok = push && !full && !clr && !pop;
  assign pop_ok  = pop && !empty && !clr;
  assign wr_idx  = IDX_W'(depth_q);
  assign top_idx = IDX_W'(depth_q - DW'(1));
  assign pop_dat = mem_q[top_idx];
  assign depth   = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (clr)          depth_d = '0;
    else if (pop_ok)  depth_d = depth_q - DW'(1);
    else if (push_ok) depth_d = depth_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  // Storage is never reset: entries above the pointer are meaningless.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= push_dat;
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter with load, relative branch, call/return via ret_stack and a sticky error flag.
// Im_Out is a register, one cycle after the inputs; no backpressure, every request is acted on or flagged.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int                 ADDR_W      = 7,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0,
  parameter int                 DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               Clock,
  input  logic               Clr_n,
  input  logic               Clr,
  input  logic               Up,
  input  logic               Load,
  input  logic               Branch,
  input  logic               Call,
  input  logic               Ret,
  input  logic [ADDR_W-1:0]  Load_Addr,
  input  logic [ADDR_W-1:0]  Offset,
  output logic [ADDR_W-1:0]  Im_Out,
  output logic [DEPTH_W-1:0] Depth,
  output logic               Stack_Full,
  output logic               Stack_Empty,
  output logic               Err
);

  pc_op_e            op;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ret_addr;
  logic              stk_push, stk_pop, stk_clr;

  assign op = decode_op(Clr, Call, Ret, Load, Branch, Up);

  assign stk_clr  = (op == OP_CLR);
  assign stk_push = (op == OP_CALL) && !Stack_Full;
  assign stk_pop  = (op == OP_RET)  && !Stack_Empty;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W),
    .DW    (DEPTH_W)
  ) u_ret_stack (
    .clk      (Clock),
    .rst_n    (Clr_n),
    .clr      (stk_clr),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_dat (pc_q + ADDR_W'(1)),
    .pop_dat  (ret_addr),
    .depth    (Depth),
    .full     (Stack_Full),
    .empty    (Stack_Empty)
  );

  // Two's-complement add at ADDR_W bits gives the signed branch with silent wrap.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    case (op)
      OP_CLR: begin
        pc_d  = RESET_ADDR;
        err_d = 1'b0;
      end
      OP_ILLEGAL: err_d = 1'b1;
      OP_RET: begin
        if (!Stack_Empty) pc_d  = ret_addr;
        else              err_d = 1'b1;
      end
      OP_CALL: begin
        if (!Stack_Full) pc_d  = Load_Addr;
        else             err_d = 1'b1;
      end
      OP_LOAD:   pc_d = Load_Addr;
      OP_BRANCH: pc_d = pc_q + Offset;
      OP_INC:    pc_d = pc_q + ADDR_W'(1);
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Clr_n) begin
    if (!Clr_n) begin
      pc_q  <= RESET_ADDR;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign Im_Out = pc_q;
  assign Err    = err_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: hand sequences for reset and wrap, then a table of single-cycle vectors.
module tb_pc_seq_unit;

  localparam int AW = 7;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          Clock = 1'b0;
  logic          Clr_n, Clr, Up, Load, Branch, Call, Ret;
  logic [AW-1:0] Load_Addr, Offset;
  logic [AW-1:0] Im_Out;
  logic [DW-1:0] Depth;
  logic          Stack_Full, Stack_Empty, Err;

  pc_seq_unit #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
    .Clock       (Clock),
    .Clr_n       (Clr_n),
    .Clr         (Clr),
    .Up          (Up),
    .Load        (Load),
    .Branch      (Branch),
    .Call        (Call),
    .Ret         (Ret),
    .Load_Addr   (Load_Addr),
    .Offset      (Offset),
    .Im_Out      (Im_Out),
    .Depth       (Depth),
    .Stack_Full  (Stack_Full),
    .Stack_Empty (Stack_Empty),
    .Err         (Err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic          clr, up, load, branch, call, ret;
    logic [AW-1:0] addr, off;
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_d;
    logic          e_err;
  } vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] d;
    logic          err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".pc"},    32'(Im_Out),      32'(e.pc));
    chk({tag, ".depth"}, 32'(Depth),       32'(e.d));
    chk({tag, ".err"},   32'(Err),         32'(e.err));
    chk({tag, ".full"},  32'(Stack_Full),  32'(e.d == DW'(SD)));
    chk({tag, ".empty"}, 32'(Stack_Empty), 32'(e.d == '0));
  endtask

  function automatic exp_t mk_exp(input logic [AW-1:0] pc, input logic [DW-1:0] d, input logic err);
    exp_t e;
    e.pc = pc; e.d = d; e.err = err;
    return e;
  endfunction

  function automatic vec_t mk(input logic clr, input logic up, input logic load, input logic branch,
                              input logic call, input logic ret, input logic [AW-1:0] addr,
                              input logic [AW-1:0] off, input logic [AW-1:0] pc,
                              input logic [DW-1:0] d, input logic err);
    vec_t v;
    v.clr = clr; v.up = up; v.load = load; v.branch = branch; v.call = call; v.ret = ret;
    v.addr = addr; v.off = off; v.e_pc = pc; v.e_d = d; v.e_err = err;
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expected result, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    exp_t got;
    Clr = v.clr; Up = v.up; Load = v.load; Branch = v.branch; Call = v.call; Ret = v.ret;
    Load_Addr = v.addr; Offset = v.off;
    sb.push_back(mk_exp(v.e_pc, v.e_d, v.e_err));
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard: got empty queue required one entry", tag);
    end else begin
      got = sb.pop_front();
      check_outs(tag, got);
    end
  endtask

  initial begin
    Clr_n = 1'b0; Clr = 0; Up = 0; Load = 0; Branch = 0; Call = 0; Ret = 0;
    Load_Addr = '0; Offset = '0;

    #3;
    check_outs("reset", mk_exp('0, '0, 1'b0));

    // Count up to 9, pulse async reset mid-cycle, then resume from 0.
    @(negedge Clock);
    Clr_n = 1'b1;
    for (int k = 1; k <= 9; k++)
      step("count", mk(0, 1, 0, 0, 0, 0, '0, '0, AW'(k), '0, 0));
    #3;
    Clr_n = 1'b0;
    #1;
    check_outs("async_rst", mk_exp('0, '0, 1'b0));
    #1;
    Clr_n = 1'b1;
    step("resume1", mk(0, 1, 0, 0, 0, 0, '0, '0, 7'd1, '0, 0));
    step("resume2", mk(0, 1, 0, 0, 0, 0, '0, '0, 7'd2, '0, 0));

    // Synchronous clear, then 130 increments to exercise wrap.
    step("sclr", mk(1, 1, 0, 0, 0, 0, '0, '0, 7'd0, '0, 0));
    for (int k = 1; k <= 130; k++)
      step("wrap", mk(0, 1, 0, 0, 0, 0, '0, '0, AW'(k % 128), '0, 0));

    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 7'h00, 7'h7D, 7'd127, 3'd0, 0)); // branch -3 from 2
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 7'h40, 7'h00, 7'd64,  3'd0, 0)); // load beats up
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 7'h05, 7'h00, 7'd5,   3'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h20, 7'h00, 7'h20,  3'd1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7'h00, 7'h00, 7'h21,  3'd1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7'h00, 7'h00, 7'h22,  3'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'd6,   3'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h10, 7'h00, 7'h10,  3'd1, 0)); // pushes 7
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h20, 7'h00, 7'h20,  3'd2, 0)); // pushes 0x11
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h30, 7'h00, 7'h30,  3'd3, 0)); // pushes 0x21
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h40, 7'h00, 7'h40,  3'd4, 0)); // pushes 0x31
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h50, 7'h00, 7'h40,  3'd4, 1)); // overflow
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'h31,  3'd3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'h21,  3'd2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'h11,  3'd1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'h07,  3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'h07,  3'd0, 1)); // underflow
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h10, 7'h00, 7'h10,  3'd1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h20, 7'h00, 7'h20,  3'd2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 7'h30, 7'h00, 7'h00,  3'd0, 0)); // clr beats call
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 7'h30, 7'h00, 7'h00,  3'd0, 1)); // illegal
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 7'h00, 7'h00, 7'h00,  3'd0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 7'h00, 7'h05, 7'h05,  3'd0, 0)); // branch beats up
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 7'h60, 7'h05, 7'h60,  3'd1, 0)); // call beats all; pushes 6
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 7'h00, 7'h00, 7'h06,  3'd0, 0)); // ret beats up
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 7'h00, 7'h7F, 7'h05,  3'd0, 0)); // branch -1
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h7F, 7'h00, 7'h7F,  3'd1, 0)); // pushes 6
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 7'h10, 7'h00, 7'h10,  3'd2, 0)); // pushes 0 (wrapped)
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'h00,  3'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'h06,  3'd0, 0));

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i]);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised program counter for the processor's instruction-memory address path; successor to the simple clear/increment counter.
- Adds width and reset-address parameters, absolute load, PC-relative branch, and call/return through an internal return-address LIFO.
- Adds full/empty status and a sticky error flag.
- Drives the instruction-memory address directly from a register; no combinational path from any input to Im_Out.

Parameters:
- ADDR_W, 7: PC / instruction-memory address width.
- STACK_DEPTH, 4: return-address LIFO entries (>=1).
- RESET_ADDR, 0: PC value after reset or clear (ADDR_W bits).

Ports:
- Clock  in  1  system clock, rising edge.
- Clr_n  in  1  asynchronous active-low reset.
- Clr  in  1  synchronous clear, active high.
- Up  in  1  increment PC.
- Load  in  1  absolute jump to Load_Addr.
- Branch  in  1  relative jump by Offset.
- Call  in  1  push return address, jump to Load_Addr.
- Ret  in  1  pop LIFO into PC.
- Load_Addr  in  ADDR_W  jump/call target.
- Offset  in  ADDR_W  two's-complement branch offset.
- Im_Out  out  ADDR_W  current PC / instruction-memory address.
- Depth  out  $clog2(STACK_DEPTH+1)  LIFO occupancy.
- Stack_Full  out  1  Depth==STACK_DEPTH.
- Stack_Empty  out  1  Depth==0.
- Err  out  1  sticky overflow/underflow/illegal-op flag.

Behaviour:
- Clr_n low, asynchronously: Im_Out=RESET_ADDR, Depth=0, Err=0. LIFO storage contents are don't-care. Deassertion is synchronised externally.
- All other updates occur on the rising edge of Clock. Latency is 1 cycle from input to Im_Out.
- Priority per cycle, highest first:
  1. Clr: Im_Out=RESET_ADDR, Depth=0, Err=0.
  2. Call&&Ret both high: illegal. PC and Depth hold; Err<=1.
  3. Ret:
     - Depth>0: Im_Out<=top entry, Depth-1.
     - Depth==0: underflow. PC holds; Err<=1.
  4. Call:
     - Depth<STACK_DEPTH: push (Im_Out+1) mod 2^ADDR_W; Im_Out<=Load_Addr; Depth+1.
     - Full: overflow. No push, PC holds; Err<=1.
  5. Load: Im_Out<=Load_Addr.
  6. Branch: Im_Out<=(Im_Out+Offset) mod 2^ADDR_W, with Offset signed.
  7. Up: Im_Out<=(Im_Out+1) mod 2^ADDR_W.
  8. None of the above: hold.
- Lower-priority inputs asserted in the same cycle are ignored. This includes Up alongside Load, Branch, Call or Ret.
- All address arithmetic is ADDR_W wide and wraps silently; wrap does not set Err.
- Err clears only via Clr or Clr_n.
- Stack_Full and Stack_Empty are combinational decodes of registered Depth.
- Reset mid-call-sequence discards all pending return addresses.

Decomposition:
- Package pc_seq_pkg:
  - enum pc_op_e {OP_HOLD, OP_INC, OP_BRANCH, OP_LOAD, OP_CALL, OP_RET, OP_CLR, OP_ILLEGAL}.
  - Priority decode function returning pc_op_e.
- Sub-module ret_stack (parametrised LIFO: push, pop, data in/out, depth, full, empty, async active-low reset of pointer only). pc_seq_unit instantiates it and owns the PC register and Err.

Test Plan:
1. Run with Up=1, assert Clr_n=0 between clock edges at Im_Out=9 -> Im_Out=0, Depth=0, Err=0 before the next edge. Release -> counting resumes from 0.
2. Up held 130 cycles from 0 -> Im_Out reaches 127, then 0, then 1, 2; Err stays 0.
3. At Im_Out=2, Branch with Offset=7'h7D (-3) -> Im_Out=127. Then Load with Load_Addr=7'h40 and Up=1 -> Im_Out=64, not 65.
4. At Im_Out=5, Call with Load_Addr=7'h20 -> Im_Out=32, Depth=1. Two Up cycles -> 34. Ret -> Im_Out=6, Depth=0, Stack_Empty=1.
5. Four nested Calls -> Depth=4, Stack_Full=1. A fifth Call -> Im_Out unchanged, Depth=4, Err=1. Four Rets pop in reverse order. A fifth Ret -> PC holds, Err stays 1.
6. Clr and Call together at Depth=2, Err=1 -> Im_Out=0, Depth=0, Err=0. Call and Ret together -> PC holds, Err=1.
